// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port 256x32 memory between
// instruction fetch and load/store, round-robin on contention.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_done,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_mask,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_done,
  output logic                    mem_request,
  output logic                    mem_we_re,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]   mem_data_in,
  output logic [DATA_WIDTH/8-1:0] mem_mask,
  input  logic [DATA_WIDTH-1:0]   mem_data_out
);

  localparam int MW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                state;
  logic                  cur_d;
  logic                  cur_we;
  logic                  last_d;
  logic [DATA_WIDTH-1:0] if_hold;
  logic [DATA_WIDTH-1:0] d_hold;

  logic go;
  logic go_d;
  logic go_st;

  // Pick the next command: tie in IDLE goes to the port not
  // served last; in RESP only the other port may be taken.
  always_comb begin
    go   = 1'b0;
    go_d = 1'b0;
    unique case (state)
      IDLE: begin
        go   = if_req | d_req;
        go_d = d_req & (~if_req | ~last_d);
      end
      RESP: begin
        go   = cur_d ? if_req : d_req;
        go_d = ~cur_d;
      end
      default: begin
        go   = 1'b0;
        go_d = 1'b0;
      end
    endcase
    go_st = go_d & d_we;
  end

  // Sequencer with registered memory strobes and done pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cur_d       <= 1'b0;
      cur_we      <= 1'b0;
      last_d      <= 1'b0;
      if_hold     <= '0;
      d_hold      <= '0;
      if_done     <= 1'b0;
      d_done      <= 1'b0;
      mem_request <= 1'b0;
      mem_we_re   <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      mem_mask    <= '0;
    end else begin
      if_done     <= 1'b0;
      d_done      <= 1'b0;
      mem_request <= 1'b0;
      mem_we_re   <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      mem_mask    <= '0;
      unique case (state)
        ISSUE: begin
          state   <= RESP;
          d_done  <= cur_d;
          if_done <= ~cur_d;
        end
        IDLE, RESP: begin
          if (state == RESP) begin
            if (!cur_d)
              if_hold <= mem_data_out;
            else if (!cur_we)
              d_hold <= mem_data_out;
          end
          if (go) begin
            state       <= ISSUE;
            cur_d       <= go_d;
            last_d      <= go_d;
            cur_we      <= go_st;
            mem_request <= 1'b1;
            mem_we_re   <= go_st;
            mem_address <= go_d ? d_addr : if_addr;
            mem_data_in <= go_st ? d_wdata : '0;
            mem_mask    <= go_st ? d_mask : {MW{1'b0}};
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign if_rdata = (state == RESP && !cur_d)
                  ? mem_data_out : if_hold;
  assign d_rdata  = (state == RESP && cur_d && !cur_we)
                  ? mem_data_out : d_hold;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench with a behavioural memory and
// a done-pulse scoreboard for mem_arbiter.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [7:0]  if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req;
  logic        d_we;
  logic [7:0]  d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_mask;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        mem_request;
  logic        mem_we_re;
  logic [7:0]  mem_address;
  logic [31:0] mem_data_in;
  logic [3:0]  mem_mask;
  logic [31:0] mem_data_out;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] exp_port[$];
  logic [31:0] exp_data[$];
  int n_req = 0;
  int n_ifd = 0;

  logic        pl_we = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  logic [31:0] mem [256];
  logic [31:0] mem_q = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_rdata     (if_rdata),
    .if_done      (if_done),
    .d_req        (d_req),
    .d_we         (d_we),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_mask       (d_mask),
    .d_rdata      (d_rdata),
    .d_done       (d_done),
    .mem_request  (mem_request),
    .mem_we_re    (mem_we_re),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_mask     (mem_mask),
    .mem_data_out (mem_data_out)
  );

  // Single-port memory, one-cycle registered read.
  always @(posedge clk) begin
    if (pl_we) begin
      mem[pl_addr] <= pl_data;
    end else if (mem_request && mem_we_re) begin
      for (int i = 0; i < 4; i++)
        if (mem_mask[i])
          mem[mem_address][8*i +: 8] <= mem_data_in[8*i +: 8];
    end
    if (mem_request && !mem_we_re)
      mem_q <= mem[mem_address];
  end
  assign mem_data_out = mem_q;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse pops one expected completion.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_request) n_req++;
      if (if_done) n_ifd++;
      if (if_done && d_done)
        chk("dual_done", 32'd1, 32'd0);
      else if (if_done || d_done) begin
        if (exp_port.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          logic [31:0] p;
          logic [31:0] e;
          p = exp_port.pop_front();
          e = exp_data.pop_front();
          chk("done_port", {31'b0, d_done}, p);
          chk("done_rdata", d_done ? d_rdata : if_rdata, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic port_d, input logic [31:0] d);
    exp_port.push_back({31'b0, port_d});
    exp_data.push_back(d);
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pl_we   = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_we   = 1'b0;
  endtask

  task automatic d_cmd(input logic we, input logic [7:0] a,
                       input logic [31:0] wd, input logic [3:0] m);
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    d_mask  = m;
  endtask

  initial begin
    int b_req;
    int b_ifd;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0;
    d_wdata = '0; d_mask = '0;
    tick();
    tick();
    chk("rst_mem_request", {31'b0, mem_request}, 32'd0);
    chk("rst_if_done", {31'b0, if_done}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    preload(8'h10, 32'hDEADBEEF);
    preload(8'h05, 32'h11223344);
    preload(8'h20, 32'h12345678);
    rst = 1'b0;
    tick();

    // Single fetch
    if_req = 1'b1; if_addr = 8'h10;
    push(1'b0, 32'hDEADBEEF);
    tick();
    chk("f_issue_req", {31'b0, mem_request}, 32'd1);
    chk("f_issue_we", {31'b0, mem_we_re}, 32'd0);
    chk("f_issue_addr", {24'b0, mem_address}, 32'h10);
    tick();
    chk("f_resp_done", {31'b0, if_done}, 32'd1);
    if_req = 1'b0;
    tick();
    chk("f_after_done", {31'b0, if_done}, 32'd0);
    chk("f_hold", if_rdata, 32'hDEADBEEF);

    // Masked store then load
    d_cmd(1'b1, 8'h05, 32'hAABBCCDD, 4'b0101);
    push(1'b1, 32'h0);
    tick();
    chk("st_we", {31'b0, mem_we_re}, 32'd1);
    chk("st_mask", {28'b0, mem_mask}, 32'h5);
    chk("st_data", mem_data_in, 32'hAABBCCDD);
    tick();
    chk("st_done", {31'b0, d_done}, 32'd1);
    d_req = 1'b0;
    tick();
    d_cmd(1'b0, 8'h05, 32'hFFFFFFFF, 4'hF);
    push(1'b1, 32'h11BB33DD);
    tick();
    chk("ld_mask_zero", {28'b0, mem_mask}, 32'h0);
    chk("ld_data_zero", mem_data_in, 32'h0);
    tick();
    d_req = 1'b0;
    tick();

    // Contention from reset: data first, then alternate
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if_req = 1'b1; if_addr = 8'h10;
    d_cmd(1'b0, 8'h05, 32'h0, 4'h0);
    push(1'b1, 32'h11BB33DD);
    push(1'b0, 32'hDEADBEEF);
    push(1'b1, 32'h11BB33DD);
    push(1'b0, 32'hDEADBEEF);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_issue", {31'b0, mem_request}, 32'd1);
      chk("rr_addr", {24'b0, mem_address},
          (k % 2 == 0) ? 32'h05 : 32'h10);
      tick();
      chk("rr_done_d", {31'b0, d_done},
          (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    tick();
    chk("rr_idle", {31'b0, mem_request}, 32'd0);

    // Stale request held into RESP
    b_req = n_req;
    b_ifd = n_ifd;
    if_req = 1'b1; if_addr = 8'h10;
    push(1'b0, 32'hDEADBEEF);
    tick();
    tick();
    tick();
    if_req = 1'b0;
    tick();
    tick();
    chk("stale_req_pulses", n_req - b_req, 32'd1);
    chk("stale_done_pulses", n_ifd - b_ifd, 32'd1);

    // Reset during ISSUE of a load
    d_cmd(1'b0, 8'h05, 32'h0, 4'h0);
    tick();
    chk("mid_issue", {31'b0, mem_request}, 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_d_done", {31'b0, d_done}, 32'd0);
    chk("mid_mem_req", {31'b0, mem_request}, 32'd0);
    chk("mid_mem_addr", {24'b0, mem_address}, 32'd0);
    chk("mid_d_rdata", d_rdata, 32'd0);
    chk("mid_if_rdata", if_rdata, 32'd0);
    rst = 1'b0;
    push(1'b1, 32'h11BB33DD);
    tick();
    tick();
    chk("mid_redo_done", {31'b0, d_done}, 32'd1);
    d_req = 1'b0;
    tick();

    // rdata hold across a store
    if_req = 1'b1; if_addr = 8'h20;
    push(1'b0, 32'h12345678);
    tick();
    tick();
    if_req = 1'b0;
    tick();
    d_cmd(1'b1, 8'h30, 32'hCAFEF00D, 4'hF);
    push(1'b1, 32'h11BB33DD);
    tick();
    tick();
    chk("hold_if", if_rdata, 32'h12345678);
    d_req = 1'b0;
    tick();
    chk("hold_d", d_rdata, 32'h11BB33DD);
    d_cmd(1'b0, 8'h30, 32'h0, 4'h0);
    push(1'b1, 32'hCAFEF00D);
    tick();
    tick();
    d_req = 1'b0;
    tick();

    for (int i = 0; i < 20 && exp_port.size() != 0; i++)
      tick();
    chk("sb_drain", exp_port.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
